fifo_drain: RTL

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: pulls words from a replay FIFO into a 2-entry skid buffer and
// presents them as valid/ready packets of burst_len words (0 means 256).
// A packet counter tracks completed packets.
// Optional build macro FIFO_DRAIN_FLUSH_EN adds a 'flush' input that drops
// buffered and in-flight words and restarts the current packet.
module fifo_drain #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef FIFO_DRAIN_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd,
  output logic          fifo_en,
  input  logic [7:0]    burst_len,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [15:0]   pkt_count
);

  // Skid buffer: buf0 is the head, buf1 the second entry.
  logic [DW-1:0] buf0;
  logic [DW-1:0] buf1;
  logic [1:0]    occ;
  logic [1:0]    occ_after_pop;
  logic [1:0]    committed;
  logic          inflight;
  logic          run_q;
  logic          pop;
  logic          flush_i;

  // Packet tracking.
  logic [7:0]    word_idx;
  logic [7:0]    len_q;
  logic [7:0]    len_eff;

`ifdef FIFO_DRAIN_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign fifo_en       = rst_n;
  assign m_valid       = (occ != 2'd0) && !flush_i;
  assign m_data        = buf0;
  assign pop           = m_valid && m_ready;
  assign occ_after_pop = occ - {1'b0, pop};

  // NOTE: a word popped at this edge frees its slot at the same edge, so the
  // pop is credited here; that keeps one word per cycle in steady state while
  // never committing more than two words after any edge.
  assign committed = occ_after_pop + {1'b0, inflight};
  assign fifo_rd   = run_q && !fifo_empty && !flush_i && (committed < 2'd2);

  // The first word of a packet sees burst_len directly; later words use the
  // value latched with that first word, so mid-packet changes are ignored.
  assign len_eff = (word_idx == 8'd0) ? burst_len : len_q;
  assign m_last  = m_valid && (word_idx == len_eff - 8'd1);

  // Skid buffer, occupancy and read pipeline.
  // NOTE: the two buffer entries are reset along with the control state so
  // m_data reads zero during reset; this is a 2-word register file, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0     <= '0;
      buf1     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the later push into buf0 deliberately
      // overrides the shift from buf1 when the buffer drains to empty.
      run_q    <= 1'b1;
      inflight <= fifo_rd;
      if (flush_i) begin
        occ <= 2'd0;
      end else begin
        if (pop) buf0 <= buf1;
        if (inflight) begin
          if (occ_after_pop == 2'd0) buf0 <= fifo_data;
          else                       buf1 <= fifo_data;
        end
        occ <= occ_after_pop + {1'b0, inflight};
      end
    end
  end

  // Word index within the packet, latched length and completed-packet count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx  <= 8'd0;
      len_q     <= 8'd0;
      pkt_count <= 16'd0;
    end else if (flush_i) begin
      word_idx <= 8'd0;
    end else begin
      if (m_valid && (word_idx == 8'd0)) len_q <= burst_len;
      if (pop) begin
        if (m_last) begin
          word_idx  <= 8'd0;
          pkt_count <= pkt_count + 16'd1;
        end else begin
          word_idx <= word_idx + 8'd1;
        end
      end
    end
  end

endmodule
